// File: rtl/multicore_io_hub.sv
// Multicore I/O hub: buffers an external sample stream in an input FIFO and
// hands one word per cycle to a requesting core by round-robin. It also
// collects core results by round-robin into an output FIFO that drains to an
// external sink.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data_i/in_valid_i external sample stream; in_ready_o = FIFO can accept
//   req_in_i             per-core level request for one input word
//   core_in_data_o       word delivered to the granted core (held between strobes)
//   core_in_valid_o      one-hot, single-cycle delivery strobe
//   io_out_i             flattened core results, core i at [i*DATA_W +: DATA_W]
//   out_en_i             per-core "result pending", held until acknowledged
//   out_ack_o            one-hot, single-cycle acknowledge
//   out_data_o/out_valid_o/out_ready_i  output stream (head of output FIFO)
//   words_in_cnt_o       words delivered to cores (wrapping)
//   words_out_cnt_o      words accepted by the sink (wrapping)
module multicore_io_hub #(
  parameter int unsigned N_CORES   = 48,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [N_CORES-1:0]        req_in_i,
  output logic [DATA_W-1:0]         core_in_data_o,
  output logic [N_CORES-1:0]        core_in_valid_o,
  input  logic [N_CORES*DATA_W-1:0] io_out_i,
  input  logic [N_CORES-1:0]        out_en_i,
  output logic [N_CORES-1:0]        out_ack_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               words_in_cnt_o,
  output logic [31:0]               words_out_cnt_o
);

  localparam int unsigned PtrW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned IAw  = $clog2(IN_DEPTH);
  localparam int unsigned OAw  = $clog2(OUT_DEPTH);

  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(N_CORES - 1);
  localparam logic [IAw-1:0]  IAdrOne  = IAw'(1);
  localparam logic [IAw:0]    ICntOne  = (IAw + 1)'(1);
  localparam logic [IAw:0]    ICntFull = (IAw + 1)'(IN_DEPTH);
  localparam logic [OAw-1:0]  OAdrOne  = OAw'(1);
  localparam logic [OAw:0]    OCntOne  = (OAw + 1)'(1);
  localparam logic [OAw:0]    OCntFull = (OAw + 1)'(OUT_DEPTH);

  // Round-robin pick: first set bit of elig at or after ptr, wrapping.
  // Returns {found, index}.
  function automatic logic [PtrW:0] rr_pick(input logic [N_CORES-1:0] elig,
                                            input logic [PtrW-1:0]    ptr);
    logic            found;
    logic [PtrW-1:0] win;
    logic [PtrW-1:0] cand;
    int unsigned     idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      cand = PtrW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // State
  logic [DATA_W-1:0]  in_mem_q [IN_DEPTH];
  logic [IAw-1:0]     in_wr_q, in_rd_q;
  logic [IAw:0]       in_cnt_q;
  logic [PtrW-1:0]    in_ptr_q;
  logic [N_CORES-1:0] core_in_valid_q;
  logic [DATA_W-1:0]  core_in_data_q;

  logic [DATA_W-1:0]  out_mem_q [OUT_DEPTH];
  logic [OAw-1:0]     out_wr_q, out_rd_q;
  logic [OAw:0]       out_cnt_q;
  logic [PtrW-1:0]    out_ptr_q;
  logic [N_CORES-1:0] out_ack_q;

  logic [31:0]        words_in_q, words_out_q;

  // Unpacked view of the core result bus
  logic [DATA_W-1:0]  io_arr [N_CORES];
  for (genvar g = 0; g < N_CORES; g++) begin : g_io_unpack
    assign io_arr[g] = io_out_i[g*DATA_W +: DATA_W];
  end

  logic            in_found, in_grant, in_push, in_full;
  logic [PtrW-1:0] in_win;
  logic            out_found, out_collect, out_pop, out_space;
  logic [PtrW-1:0] out_win;

  always_comb begin
    // A core is never eligible in the cycle it is being strobed / acked.
    {in_found, in_win}   = rr_pick(req_in_i & ~core_in_valid_q, in_ptr_q);
    {out_found, out_win} = rr_pick(out_en_i & ~out_ack_q, out_ptr_q);

    in_full  = (in_cnt_q == ICntFull);
    in_grant = in_found && (in_cnt_q != '0);
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    in_ready_o = rst_n && (!in_full || in_grant);
    in_push    = in_valid_i && in_ready_o;

    out_valid_o = (out_cnt_q != '0);
    out_pop     = out_valid_o && out_ready_i;
    out_space   = (out_cnt_q != OCntFull) || out_pop;
    out_collect = out_found && out_space;
    out_data_o  = out_valid_o ? out_mem_q[out_rd_q] : '0;
  end

  assign core_in_data_o  = core_in_data_q;
  assign core_in_valid_o = core_in_valid_q;
  assign out_ack_o       = out_ack_q;
  assign words_in_cnt_o  = words_in_q;
  assign words_out_cnt_o = words_out_q;

  // FIFO storage needs no reset; occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (in_push)     in_mem_q[in_wr_q]   <= in_data_i;
    if (out_collect) out_mem_q[out_wr_q] <= io_arr[out_win];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_q         <= '0;
      in_rd_q         <= '0;
      in_cnt_q        <= '0;
      in_ptr_q        <= '0;
      core_in_valid_q <= '0;
      core_in_data_q  <= '0;
      out_wr_q        <= '0;
      out_rd_q        <= '0;
      out_cnt_q       <= '0;
      out_ptr_q       <= '0;
      out_ack_q       <= '0;
      words_in_q      <= '0;
      words_out_q     <= '0;
    end else begin
      // Input side
      if (in_push) in_wr_q <= in_wr_q + IAdrOne;
      if (in_grant) begin
        in_rd_q        <= in_rd_q + IAdrOne;
        core_in_data_q <= in_mem_q[in_rd_q];
        in_ptr_q       <= (in_win == PtrLast) ? '0 : in_win + PtrOne;
        words_in_q     <= words_in_q + 32'd1;
      end
      core_in_valid_q <= in_grant ? (N_CORES'(1) << in_win) : '0;
      if (in_push && !in_grant)      in_cnt_q <= in_cnt_q + ICntOne;
      else if (!in_push && in_grant) in_cnt_q <= in_cnt_q - ICntOne;

      // Output side
      if (out_collect) begin
        out_wr_q  <= out_wr_q + OAdrOne;
        out_ptr_q <= (out_win == PtrLast) ? '0 : out_win + PtrOne;
      end
      out_ack_q <= out_collect ? (N_CORES'(1) << out_win) : '0;
      if (out_pop) begin
        out_rd_q    <= out_rd_q + OAdrOne;
        words_out_q <= words_out_q + 32'd1;
      end
      if (out_collect && !out_pop)      out_cnt_q <= out_cnt_q + OCntOne;
      else if (!out_collect && out_pop) out_cnt_q <= out_cnt_q - OCntOne;
    end
  end

endmodule
